grid_capture: RTL and testbench
===============================

Name: grid_capture

Overview:
- Receiving end of the plot interface (x, y, colour, plot) that the simulation drives toward the VGA adapter.
- Mirrors every plotted pixel into a 1-bit-per-cell grid store. alive = (colour != 0).
- Keeps a running live-cell count.
- Offers a row-major scan-out stream with valid/ready handshake, so a checker or next-generation engine can read the board back.
- Sits beside vga_adapter on the same plot bus; never drives the plot bus.

Parameters:
- GRID_W, 16, cells per row; x range 0..GRID_W-1.
- GRID_H, 16, cells per column; y range 0..GRID_H-1.
- COORD_W, 8, width of x/y on the plot bus and on the read port.
- CNT_W, 9, live-count width; must hold GRID_W*GRID_H (256).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- x  in  COORD_W  plot column.
- y  in  COORD_W  plot row.
- colour  in  3  plot colour; nonzero = alive, 3'b000 = dead.
- plot  in  1  write strobe; sampled every rising clock edge.
- scan_start  in  1  single-cycle request to begin a full-grid readout.
- rd_ready  in  1  consumer accepts the current beat.
- rd_valid  out  1  read beat present.
- rd_x  out  COORD_W  column of the presented cell.
- rd_y  out  COORD_W  row of the presented cell.
- rd_alive  out  1  state of the presented cell.
- scan_done  out  1  one-cycle pulse after the last beat is accepted.
- busy  out  1  high while a scan is in progress.
- live_count  out  CNT_W  number of alive cells.
- oob_write  out  1  sticky flag: a plot was received with x >= GRID_W or y >= GRID_H.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - All cells cleared to 0; live_count = 0; state = IDLE.
  - rd_valid, rd_x, rd_y, rd_alive, scan_done, busy, oob_write all 0.
  - Reset asserted mid-scan aborts the scan immediately; no scan_done is issued.
- Write path:
  - When plot = 1 at the edge and the coordinate is in range, cell[y][x] <= (colour != 0). Write latency is 1 cycle.
  - Out-of-range plot: the grid is not modified and oob_write is set to 1 until reset.
- live_count update (same edge as the write):
  - +1 only on a dead->alive transition; -1 only on alive->dead.
  - Rewriting the same state leaves the count unchanged. The count therefore never exceeds GRID_W*GRID_H and never underflows.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: busy = 0, rd_valid = 0. scan_start = 1 moves to SCAN; the first beat (0,0) is loaded on the same edge, so rd_valid = 1 one cycle after scan_start.
  - SCAN: busy = 1, rd_valid = 1.
    - On rd_valid & rd_ready, the next cell loads in row-major order: x increments; when x = GRID_W-1, x wraps to 0 and y increments.
    - Handshake on cell (GRID_W-1, GRID_H-1) moves to DONE with rd_valid <= 0.
    - scan_start is ignored while in SCAN.
  - DONE: scan_done = 1 for exactly one cycle; busy = 0; return to IDLE. scan_start is accepted again from IDLE on the next cycle.
- Beat stability:
  - While rd_valid = 1 and rd_ready = 0, rd_x, rd_y and rd_alive hold. This holds even if a plot rewrites the presented cell.
  - A beat's rd_alive is sampled when the beat is loaded. If a plot targets the cell being loaded on that same edge, the loaded value is the new written value (write-bypass).
- Throughput: one beat per cycle when rd_ready is held high. A full 16x16 scan takes 256 beats, plus 1 cycle for scan_done.
- Plot and scan run concurrently with no stall; the plot bus is never back-pressured.

Decomposition:
- Package grid_pkg holds:
  - GRID_W, GRID_H, COORD_W, CNT_W defaults.
  - Colour constants COLOUR_DEAD = 3'b000, COLOUR_ALIVE = 3'b111.
  - The FSM state encoding.
- One natural sub-module, grid_scan_ctrl: the IDLE/SCAN/DONE FSM plus the x/y scan counters and the handshake logic.
- The top level holds the cell store, the write decode, live_count and oob_write.

Test Plan:
- Reset, then scan_start with rd_ready = 1 -> 256 beats, all rd_alive = 0, coordinates in order (0,0),(1,0)..(15,15); scan_done pulses once, 1 cycle after the last beat; live_count = 0.
- Plot (3,2,7), (3,2,7) again, then (3,2,0) -> live_count goes 1, stays 1, returns to 0; a scan in between shows rd_alive = 1 only at beat index 35.
- Plot (20,5,7) -> grid unchanged, live_count unchanged, oob_write = 1 and stays set until reset_n pulses low.
- Scan with rd_ready low while beat (4,0) is presented, and plot (4,0,7) during the stall -> rd_alive stays 0 until the handshake; a rescan shows 1.
- Plot to cell (5,0) on the same edge that beat (5,0) loads -> the beat shows rd_alive = 1 (bypass).
- Assert reset_n = 0 at beat 100 of a scan -> rd_valid and busy drop immediately, no scan_done; after release a new scan_start completes normally with all-zero cells.

Source files
------------

// File: rtl/grid_pkg.sv
// Purpose: shared sizes, colour constants and scan FSM encoding for grid_capture.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grid_pkg;

    localparam int GRID_W_DEFAULT  = 16;
    localparam int GRID_H_DEFAULT  = 16;
    localparam int COORD_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT   = 9;

    localparam logic [2:0] COLOUR_DEAD  = 3'b000;
    localparam logic [2:0] COLOUR_ALIVE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/grid_scan_ctrl.sv
// Purpose: row-major scan-out sequencer (IDLE/SCAN/DONE) with x/y counters and valid/ready beat register.
// Latency: first beat valid 1 cycle after scan_start_i; one beat per cycle while ready is high.
// Backpressure: beat (coords + alive) holds while rd_ready_i is low; scan_start_i ignored unless IDLE.
// Ports: scan_start_i/rd_ready_i in; ld_* tells the owner of the cell store which cell loads this
// edge and takes back its (write-bypassed) value on ld_alive_i; rd_*/busy_o/scan_done_o out.
module grid_scan_ctrl
    import grid_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEFAULT,
    parameter int GRID_H  = GRID_H_DEFAULT,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               scan_start_i,
    input  logic               rd_ready_i,
    input  logic               ld_alive_i,
    output logic               ld_en_o,
    output logic [COORD_W-1:0] ld_x_o,
    output logic [COORD_W-1:0] ld_y_o,
    output logic               rd_valid_o,
    output logic [COORD_W-1:0] rd_x_o,
    output logic [COORD_W-1:0] rd_y_o,
    output logic               rd_alive_o,
    output logic               busy_o,
    output logic               scan_done_o
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);

    scan_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic               alive_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_en_o) begin
                x_q     <= ld_x_o;
                y_q     <= ld_y_o;
                alive_q <= ld_alive_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ld_en_o = 1'b0;
        ld_x_o  = '0;
        ld_y_o  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (scan_start_i) begin
                    state_d = ST_SCAN;
                    ld_en_o = 1'b1;
                end
            end
            ST_SCAN: begin
                if (rd_ready_i) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        ld_en_o = 1'b1;
                        if (x_q == X_LAST) begin
                            ld_x_o = '0;
                            ld_y_o = y_q + 1'b1;
                        end else begin
                            ld_x_o = x_q + 1'b1;
                            ld_y_o = y_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid is a pure decode of SCAN so an asynchronous reset drops it in the same instant.
    assign rd_valid_o  = (state_q == ST_SCAN);
    assign busy_o      = (state_q == ST_SCAN);
    assign scan_done_o = (state_q == ST_DONE);
    assign rd_x_o      = x_q;
    assign rd_y_o      = y_q;
    assign rd_alive_o  = alive_q;

endmodule

// File: rtl/grid_capture.sv
// Purpose: snoops the plot bus into a 1-bit-per-cell grid, keeps a live-cell count, offers row-major readout.
// Latency: plot -> cell/live_count 1 cycle; scan_start -> first beat 1 cycle, then 1 beat/cycle.
// Backpressure: plot bus never stalled; readout beats hold while rd_ready is low.
// Ports: x/y/colour/plot = plot bus (input only); scan_start/rd_ready + rd_* = readout stream;
// scan_done/busy = scan status; live_count = alive cells; oob_write = sticky out-of-range plot flag.
module grid_capture
    import grid_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEFAULT,
    parameter int GRID_H  = GRID_H_DEFAULT,
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [2:0]         colour,
    input  logic               plot,
    input  logic               scan_start,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_alive,
    output logic               scan_done,
    output logic               busy,
    output logic [CNT_W-1:0]   live_count,
    output logic               oob_write
);

    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IDX_W   = $clog2(N_CELLS);

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] cx,
                                                  input logic [COORD_W-1:0] cy);
        return IDX_W'(int'(cy) * GRID_W + int'(cx));
    endfunction

    logic [N_CELLS-1:0] cells_q, cells_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               oob_q, oob_d;

    logic               in_range;
    logic               wr_en;
    logic               wr_alive;
    logic [IDX_W-1:0]   wr_idx;
    logic               old_alive;

    logic               ld_en;
    logic [COORD_W-1:0] ld_x, ld_y;
    logic               ld_alive;

    assign in_range  = (x < COORD_W'(GRID_W)) && (y < COORD_W'(GRID_H));
    assign wr_en     = plot && in_range;
    assign wr_alive  = (colour != COLOUR_DEAD);
    assign wr_idx    = cell_idx(x, y);
    assign old_alive = cells_q[wr_idx];

    always_comb begin
        cells_d = cells_q;
        count_d = count_q;
        oob_d   = oob_q | (plot & ~in_range);
        if (wr_en) begin
            cells_d[wr_idx] = wr_alive;
            // Only real state changes move the count, so it stays within 0..N_CELLS.
            if (wr_alive && !old_alive) begin
                count_d = count_q + 1'b1;
            end else if (!wr_alive && old_alive) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Sampling the next-state grid gives write-bypass when a plot hits the cell being loaded.
    assign ld_alive = cells_d[cell_idx(ld_x, ld_y)];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cells_q <= '0;
            count_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            cells_q <= cells_d;
            count_q <= count_d;
            oob_q   <= oob_d;
        end
    end

    assign live_count = count_q;
    assign oob_write  = oob_q;

    grid_scan_ctrl #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .COORD_W (COORD_W)
    ) u_scan (
        .clock        (clock),
        .reset_n      (reset_n),
        .scan_start_i (scan_start),
        .rd_ready_i   (rd_ready),
        .ld_alive_i   (ld_alive),
        .ld_en_o      (ld_en),
        .ld_x_o       (ld_x),
        .ld_y_o       (ld_y),
        .rd_valid_o   (rd_valid),
        .rd_x_o       (rd_x),
        .rd_y_o       (rd_y),
        .rd_alive_o   (rd_alive),
        .busy_o       (busy),
        .scan_done_o  (scan_done)
    );

endmodule

// File: tb/tb_grid_capture.sv
// Purpose: directed self-checking bench for grid_capture with a bench-side grid/count model.
// Latency: n/a.
// Backpressure: drives rd_ready directly, including stalls.
module tb_grid_capture;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] x, y;
    logic [2:0] colour;
    logic       plot, scan_start, rd_ready;
    logic       rd_valid, rd_alive, scan_done, busy, oob_write;
    logic [7:0] rd_x, rd_y;
    logic [8:0] live_count;

    int         n_vec = 0;
    int         n_err = 0;
    logic [255:0] exp_map;
    int         exp_cnt;

    always #5 clock = ~clock;

    grid_capture dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .scan_start (scan_start),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_alive   (rd_alive),
        .scan_done  (scan_done),
        .busy       (busy),
        .live_count (live_count),
        .oob_write  (oob_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        x      = 8'(px);
        y      = 8'(py);
        colour = c;
        plot   = 1'b1;
        @(negedge clock);
        plot   = 1'b0;
        if (px < 16 && py < 16) begin
            if (c != 3'b000 && !exp_map[py*16+px]) exp_cnt++;
            if (c == 3'b000 &&  exp_map[py*16+px]) exp_cnt--;
            exp_map[py*16+px] = (c != 3'b000);
        end
    endtask

    task automatic start_scan();
        scan_start = 1'b1;
        rd_ready   = 1'b1;
        @(negedge clock);
        scan_start = 1'b0;
    endtask

    task automatic full_scan();
        start_scan();
        chk("scan_busy", busy, 1);
        for (int i = 0; i < 256; i++) begin
            chk("beat_vld", rd_valid, 1);
            chk("beat_x", rd_x, i % 16);
            chk("beat_y", rd_y, i / 16);
            chk("beat_alive", rd_alive, exp_map[i]);
            chk("early_done", scan_done, 0);
            @(negedge clock);
        end
        chk("done_pulse", scan_done, 1);
        chk("done_vld", rd_valid, 0);
        chk("done_busy", busy, 0);
        @(negedge clock);
        chk("done_once", scan_done, 0);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (scan_done) seen = 1'b1;
            else @(negedge clock);
        end
        chk("done_seen", seen, 1);
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; x = '0; y = '0; colour = '0;
        plot = 1'b0; scan_start = 1'b0; rd_ready = 1'b0;
        exp_map = '0; exp_cnt = 0;
        repeat (3) @(negedge clock);
        chk("rst_vld", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_cnt", live_count, 0);
        chk("rst_oob", oob_write, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Empty board readout
        full_scan();
        chk("cnt_empty", live_count, 0);

        // Set, rewrite, clear one cell at index 35
        plot_px(3, 2, 3'b111);
        chk("cnt_set", live_count, 1);
        plot_px(3, 2, 3'b111);
        chk("cnt_rewrite", live_count, 1);
        full_scan();
        plot_px(3, 2, 3'b000);
        chk("cnt_clear", live_count, 0);

        // Out-of-range plot
        plot_px(20, 5, 3'b111);
        chk("oob_set", oob_write, 1);
        chk("oob_cnt", live_count, 0);
        full_scan();
        chk("oob_sticky", oob_write, 1);

        // Stall on beat (4,0) while plotting it
        start_scan();
        repeat (4) @(negedge clock);
        chk("stall_x", rd_x, 4);
        rd_ready = 1'b0;
        plot_px(4, 0, 3'b111);
        chk("stall_hold_x", rd_x, 4);
        chk("stall_hold_alive", rd_alive, 0);
        chk("stall_cnt", live_count, 1);
        @(negedge clock);
        chk("stall_hold2", rd_alive, 0);
        rd_ready = 1'b1;
        @(negedge clock);
        chk("stall_next_x", rd_x, 5);
        wait_done(300);
        full_scan();

        // Bypass: plot (5,0) on the edge that loads beat (5,0)
        start_scan();
        repeat (4) @(negedge clock);
        chk("byp_x", rd_x, 4);
        plot_px(5, 0, 3'b101);
        chk("byp_beat_x", rd_x, 5);
        chk("byp_alive", rd_alive, 1);
        chk("byp_cnt", live_count, 2);
        wait_done(300);

        // Reset mid-scan at beat 100
        start_scan();
        repeat (100) @(negedge clock);
        chk("b100_x", rd_x, 4);
        chk("b100_y", rd_y, 6);
        reset_n = 1'b0;
        #1;
        chk("arst_vld", rd_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clock);
        chk("arst_no_done", scan_done, 0);
        chk("arst_oob", oob_write, 0);
        chk("arst_cnt", live_count, 0);
        reset_n = 1'b1;
        exp_map = '0;
        exp_cnt = 0;
        @(negedge clock);
        chk("post_rst_done", scan_done, 0);
        full_scan();
        chk("final_cnt", live_count, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
